freq_rotate: RTL and testbench

- Complex phase-rotation stage directly upstream of the gain/zoom stage in the FFT processing chain.
- Takes the FFT output I/Q stream (valid/last framed, no backpressure) and multiplies each bin k by a Q1.15 coefficient pair (cos_k, sin_k), read from a coefficient RAM by bin index.
- Emits the rotate I/Q stream consumed by the zoom stage.
- Active only in mode ACTIVE_MODE; switches in and out only on frame boundaries.

---
 rtl/freq_rotate.sv | 206 ++++++++++++++++++++
 tb/tb_freq_rotate.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_rotate.sv
// freq_rotate: multiplies each FFT bin by a Q1.15 (cos_k, sin_k) pair
// read by bin index, ahead of the zoom stage. Latency is 3 cycles.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_mode                  operating mode; block runs when == ACTIVE_MODE
//   i_fft_I/Q_data          signed FFT sample
//   i_fft_valid/last        sample framing (no backpressure)
//   o_ram_rot_addr          coefficient RAM address (index of next sample)
//   i_ram_cos/sin           Q1.15 coefficients, 1-cycle read latency
//   o_rotate_I/Q_data       rotated sample, held while valid is low
//   o_rotate_valid/last     output framing
//   o_frame_err             one-cycle pulse on a frame-length violation
module freq_rotate #(
  parameter int         FFT_POINT   = 8192,
  parameter int         ADDR_WIDTH  = 14,
  parameter logic [7:0] ACTIVE_MODE = 8'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i_mode,
  input  logic signed [15:0]    i_fft_I_data,
  input  logic signed [15:0]    i_fft_Q_data,
  input  logic                  i_fft_valid,
  input  logic                  i_fft_last,
  output logic [ADDR_WIDTH-1:0] o_ram_rot_addr,
  input  logic signed [15:0]    i_ram_cos,
  input  logic signed [15:0]    i_ram_sin,
  output logic signed [15:0]    o_rotate_I_data,
  output logic signed [15:0]    o_rotate_Q_data,
  output logic                  o_rotate_valid,
  output logic                  o_rotate_last,
  output logic                  o_frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(FFT_POINT - 1);

  // control
  state_e                state_q, state_d;
  logic                  in_frame_q, in_frame_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  mode_on;
  logic                  accept;
  logic                  at_end;

  // stage 1
  logic signed [15:0]    s1_i_q, s1_i_d;
  logic signed [15:0]    s1_q_q, s1_q_d;
  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_last_q, s1_last_d;

  // stage 2
  logic signed [31:0]    p_ac, p_bs, p_as, p_bc;
  logic signed [32:0]    s2_isum_q, s2_isum_d;
  logic signed [32:0]    s2_qsum_q, s2_qsum_d;
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_last_q, s2_last_d;

  // stage 3
  logic signed [15:0]    out_i_q, out_i_d;
  logic signed [15:0]    out_q_q, out_q_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;

  assign mode_on = (i_mode == ACTIVE_MODE);
  assign accept  = (state_q == WORK) && i_fft_valid;
  assign at_end  = (addr_q == LAST_ADDR);

  // Round half up at bit 14, drop 15 fraction bits, clamp to 16 bits.
  function automatic logic signed [15:0] rnd_sat(
    input logic signed [32:0] x
  );
    logic signed [17:0] sh;
    sh = 18'((x + 33'sd16384) >>> 15);
    if (sh > 18'sd32767)
      rnd_sat = 16'sh7fff;
    else if (sh < -18'sd32768)
      rnd_sat = 16'sh8000;
    else
      rnd_sat = sh[15:0];
  endfunction

  // Tracks frame boundaries in every state so a frame already
  // running when the mode turns on is skipped as a whole.
  always_comb begin
    in_frame_d = in_frame_q;
    if (i_fft_valid)
      in_frame_d = !i_fft_last;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (mode_on && !in_frame_q && !i_fft_valid)
          state_d = WORK;
      end
      WORK: begin
        if (accept) begin
          if (i_fft_last || at_end)
            addr_d = '0;
          else
            addr_d = addr_q + ADDR_WIDTH'(1);
          // short frame (last early) or long frame (no last at end)
          err_d = i_fft_last ^ at_end;
          if (i_fft_last && !mode_on)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S1: capture the sample; the RAM word for its address lands
  // in the same cycle this stage is presented to S2.
  always_comb begin
    s1_vld_d  = accept;
    s1_last_d = accept && i_fft_last;
    s1_i_d    = accept ? i_fft_I_data : s1_i_q;
    s1_q_d    = accept ? i_fft_Q_data : s1_q_q;
  end

  // S2: (a + jb)(c + js) = (ac - bs) + j(as + bc)
  always_comb begin
    p_ac      = 32'(s1_i_q) * 32'(i_ram_cos);
    p_bs      = 32'(s1_q_q) * 32'(i_ram_sin);
    p_as      = 32'(s1_i_q) * 32'(i_ram_sin);
    p_bc      = 32'(s1_q_q) * 32'(i_ram_cos);
    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_last_q;
    s2_isum_d = s2_isum_q;
    s2_qsum_d = s2_qsum_q;
    if (s1_vld_q) begin
      s2_isum_d = 33'(p_ac) - 33'(p_bs);
      s2_qsum_d = 33'(p_as) + 33'(p_bc);
    end
  end

  // S3: round, saturate, hold data across gaps.
  always_comb begin
    out_vld_d  = s2_vld_q;
    out_last_d = s2_last_q;
    out_i_d    = out_i_q;
    out_q_d    = out_q_q;
    if (s2_vld_q) begin
      out_i_d = rnd_sat(s2_isum_q);
      out_q_d = rnd_sat(s2_qsum_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_frame_q <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_isum_q  <= '0;
      s2_qsum_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s2_isum_q  <= s2_isum_d;
      s2_qsum_q  <= s2_qsum_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      out_i_q    <= out_i_d;
      out_q_q    <= out_q_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

  assign o_ram_rot_addr  = addr_q;
  assign o_frame_err     = err_q;
  assign o_rotate_I_data = out_i_q;
  assign o_rotate_Q_data = out_q_q;
  assign o_rotate_valid  = out_vld_q;
  assign o_rotate_last   = out_last_q;

endmodule

// File: tb/tb_freq_rotate.sv
// tb_freq_rotate: directed checks of freq_rotate with an 8-point frame
// and a 1-cycle-latency coefficient RAM model.
module tb_freq_rotate;

  logic               clk;
  logic               rst_n;
  logic [7:0]         i_mode;
  logic signed [15:0] i_fft_I_data;
  logic signed [15:0] i_fft_Q_data;
  logic               i_fft_valid;
  logic               i_fft_last;
  logic [2:0]         o_ram_rot_addr;
  logic signed [15:0] ram_cos;
  logic signed [15:0] ram_sin;
  logic signed [15:0] o_rotate_I_data;
  logic signed [15:0] o_rotate_Q_data;
  logic               o_rotate_valid;
  logic               o_rotate_last;
  logic               o_frame_err;

  freq_rotate #(
    .FFT_POINT  (8),
    .ADDR_WIDTH (3),
    .ACTIVE_MODE(8'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mode         (i_mode),
    .i_fft_I_data   (i_fft_I_data),
    .i_fft_Q_data   (i_fft_Q_data),
    .i_fft_valid    (i_fft_valid),
    .i_fft_last     (i_fft_last),
    .o_ram_rot_addr (o_ram_rot_addr),
    .i_ram_cos      (ram_cos),
    .i_ram_sin      (ram_sin),
    .o_rotate_I_data(o_rotate_I_data),
    .o_rotate_Q_data(o_rotate_Q_data),
    .o_rotate_valid (o_rotate_valid),
    .o_rotate_last  (o_rotate_last),
    .o_frame_err    (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] cos_tab [8];
  logic signed [15:0] sin_tab [8];

  always @(posedge clk) begin
    ram_cos <= cos_tab[o_ram_rot_addr];
    ram_sin <= sin_tab[o_ram_rot_addr];
  end

  logic signed [15:0] got_i [$];
  logic signed [15:0] got_q [$];
  logic               got_l [$];
  int                 err_pulses;

  always @(negedge clk) begin
    if (o_rotate_valid) begin
      got_i.push_back(o_rotate_I_data);
      got_q.push_back(o_rotate_Q_data);
      got_l.push_back(o_rotate_last);
    end
    if (o_frame_err)
      err_pulses++;
  end

  int         n_vec;
  int         n_bad;
  logic [7:0] mode_req;

  task automatic clear_log();
    got_i.delete();
    got_q.delete();
    got_l.delete();
    err_pulses = 0;
  endtask

  task automatic set_tab(input logic signed [15:0] ce,
                         input logic signed [15:0] se,
                         input logic signed [15:0] co,
                         input logic signed [15:0] so);
    for (int k = 0; k < 8; k++) begin
      cos_tab[k] = k[0] ? co : ce;
      sin_tab[k] = k[0] ? so : se;
    end
  endtask

  task automatic drive(input logic v, input logic l,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_mode       = mode_req;
    i_fft_valid  = v;
    i_fft_last   = l;
    i_fft_I_data = a;
    i_fft_Q_data = b;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++)
      drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Sample k carries (base + 100k + 10, -50k - 5).
  task automatic send_frame(input int n, input int last_idx,
                            input int base, input int mode_at,
                            input logic [7:0] mode_val);
    for (int k = 0; k < n; k++) begin
      if (k == mode_at)
        mode_req = mode_val;
      drive(1'b1, k == last_idx, 16'(base + 100 * k + 10),
            16'(-50 * k - 5));
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (o_rotate_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %0b want 0", o_rotate_valid);
    end
    n_vec++;
    if (o_rotate_last !== 1'b0) begin
      n_bad++; $display("FAIL rst_last got %0b want 0", o_rotate_last);
    end
    n_vec++;
    if (o_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_err got %0b want 0", o_frame_err);
    end
    n_vec++;
    if (o_ram_rot_addr !== 3'd0) begin
      n_bad++; $display("FAIL rst_addr got %0d want 0", o_ram_rot_addr);
    end
    n_vec++;
    if (o_rotate_I_data !== 16'sd0 || o_rotate_Q_data !== 16'sd0) begin
      n_bad++;
      $display("FAIL rst_data got %0d,%0d want 0,0",
               o_rotate_I_data, o_rotate_Q_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    set_tab(16'sd32767, 16'sd0, 16'sd32767, 16'sd0);
    mode_req = 8'd4;
    idle_cycles(3);
    clear_log();
    drive(1'b1, 1'b0, 16'sd1000, -16'sd2000);
    n_vec++;
    if (o_ram_rot_addr !== 3'd0) begin
      n_bad++; $display("FAIL id_addr0 got %0d want 0", o_ram_rot_addr);
    end
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      n_vec++;
      if (o_rotate_valid !== (c == 3)) begin
        n_bad++;
        $display("FAIL id_lat c%0d got %0b want %0b",
                 c, o_rotate_valid, c == 3);
      end
    end
    n_vec++;
    if (o_rotate_I_data !== 16'sd1000 || o_rotate_Q_data !== -16'sd2000)
    begin
      n_bad++;
      $display("FAIL id_data got %0d,%0d want 1000,-2000",
               o_rotate_I_data, o_rotate_Q_data);
    end
    for (int k = 1; k < 8; k++)
      drive(1'b1, k == 7, 16'sd1000, -16'sd2000);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8 || err_pulses != 0) begin
      n_bad++;
      $display("FAIL id_frame got n=%0d err=%0d want n=8 err=0",
               got_i.size(), err_pulses);
    end
  endtask

  task automatic test_rot90();
    set_tab(16'sd0, 16'sd32767, 16'sd0, 16'sd32767);
    clear_log();
    for (int k = 0; k < 8; k++)
      drive(1'b1, k == 7, 16'sd1000, -16'sd2000);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8) begin
      n_bad++; $display("FAIL r90_count got %0d want 8", got_i.size());
    end else begin
      n_vec++;
      if (got_i[0] !== 16'sd2000 || got_q[0] !== 16'sd1000) begin
        n_bad++;
        $display("FAIL r90_data got %0d,%0d want 2000,1000",
                 got_i[0], got_q[0]);
      end
    end
  endtask

  task automatic test_saturation();
    set_tab(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
    clear_log();
    for (int k = 0; k < 8; k++)
      drive(1'b1, k == 7, -16'sd32768, -16'sd32768);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8) begin
      n_bad++; $display("FAIL sat_count got %0d want 8", got_i.size());
    end else begin
      n_vec++;
      if (got_i[0] !== 16'sd0 || got_q[0] !== 16'sd32767) begin
        n_bad++;
        $display("FAIL sat_data got %0d,%0d want 0,32767",
                 got_i[0], got_q[0]);
      end
      n_vec++;
      if (got_q[7] !== 16'sd32767 || got_l[7] !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_tail got q=%0d l=%0b want q=32767 l=1",
                 got_q[7], got_l[7]);
      end
    end
  endtask

  // Even bins identity, odd bins +90 degrees:
  // even -> (I, Q), odd -> (-Q, I).
  task automatic test_framing();
    set_tab(16'sd32767, 16'sd0, 16'sd0, 16'sd32767);
    clear_log();
    for (int k = 0; k < 8; k++) begin
      if (k > 0)
        idle_cycles($urandom_range(0, 2));
      drive(1'b1, k == 7, 16'(100 * k + 10), 16'(-50 * k - 5));
      n_vec++;
      if (o_ram_rot_addr !== 3'(k)) begin
        n_bad++;
        $display("FAIL frm_addr k%0d got %0d want %0d",
                 k, o_ram_rot_addr, k);
      end
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_ram_rot_addr !== 3'd0) begin
      n_bad++; $display("FAIL frm_wrap got %0d want 0", o_ram_rot_addr);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_rotate_last !== 1'b0) begin
      n_bad++; $display("FAIL frm_last_early got %0b want 0", o_rotate_last);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_rotate_valid !== 1'b1 || o_rotate_last !== 1'b1) begin
      n_bad++;
      $display("FAIL frm_last_lat got v=%0b l=%0b want 1,1",
               o_rotate_valid, o_rotate_last);
    end
    idle_cycles(4);
    n_vec++;
    if (got_i.size() != 8 || err_pulses != 0) begin
      n_bad++;
      $display("FAIL frm_count got n=%0d err=%0d want n=8 err=0",
               got_i.size(), err_pulses);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (k[0] == 1'b0 &&
            (got_i[k] !== 16'(100 * k + 10) ||
             got_q[k] !== 16'(-50 * k - 5))) begin
          n_bad++;
          $display("FAIL frm_even k%0d got %0d,%0d want %0d,%0d", k,
                   got_i[k], got_q[k], 100 * k + 10, -50 * k - 5);
        end
        if (k[0] == 1'b1 &&
            (got_i[k] !== 16'(50 * k + 5) ||
             got_q[k] !== 16'(100 * k + 10))) begin
          n_bad++;
          $display("FAIL frm_odd k%0d got %0d,%0d want %0d,%0d", k,
                   got_i[k], got_q[k], 50 * k + 5, 100 * k + 10);
        end
        n_vec++;
        if (got_l[k] !== (k == 7)) begin
          n_bad++;
          $display("FAIL frm_lastflag k%0d got %0b want %0b",
                   k, got_l[k], k == 7);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    set_tab(16'sd32767, 16'sd0, 16'sd32767, 16'sd0);
    clear_log();
    send_frame(6, 5, 0, -1, 8'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_frame_err !== 1'b1 || o_ram_rot_addr !== 3'd0) begin
      n_bad++;
      $display("FAIL short_err got err=%0b addr=%0d want 1,0",
               o_frame_err, o_ram_rot_addr);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL short_pulse got %0b want 0", o_frame_err);
    end
    idle_cycles(4);
    n_vec++;
    if (got_i.size() != 6) begin
      n_bad++; $display("FAIL short_count got %0d want 6", got_i.size());
    end else begin
      n_vec++;
      if (got_l[5] !== 1'b1 || got_i[5] !== 16'sd510) begin
        n_bad++;
        $display("FAIL short_last got l=%0b i=%0d want 1,510",
                 got_l[5], got_i[5]);
      end
    end
    clear_log();
    send_frame(8, -1, 0, -1, 8'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_vec++;
    if (o_frame_err !== 1'b1 || o_ram_rot_addr !== 3'd0) begin
      n_bad++;
      $display("FAIL long_err got err=%0b addr=%0d want 1,0",
               o_frame_err, o_ram_rot_addr);
    end
    send_frame(8, 7, 0, -1, 8'd0);
    idle_cycles(6);
    n_vec++;
    if (err_pulses != 1 || got_i.size() != 16) begin
      n_bad++;
      $display("FAIL long_tail got err=%0d n=%0d want 1,16",
               err_pulses, got_i.size());
    end
  endtask

  task automatic test_mode_clear();
    clear_log();
    send_frame(8, 7, 0, 3, 8'd0);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8) begin
      n_bad++; $display("FAIL mclr_count got %0d want 8", got_i.size());
    end else begin
      n_vec++;
      if (got_i[7] !== 16'sd710 || got_q[7] !== -16'sd355 ||
          got_l[7] !== 1'b1) begin
        n_bad++;
        $display("FAIL mclr_tail got %0d,%0d l=%0b want 710,-355 l=1",
                 got_i[7], got_q[7], got_l[7]);
      end
    end
    n_vec++;
    if (o_ram_rot_addr !== 3'd0) begin
      n_bad++; $display("FAIL mclr_addr got %0d want 0", o_ram_rot_addr);
    end
    clear_log();
    send_frame(8, 7, 0, -1, 8'd0);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 0) begin
      n_bad++; $display("FAIL mclr_idle got %0d want 0", got_i.size());
    end
  endtask

  task automatic test_mode_enable();
    clear_log();
    send_frame(8, 7, 1000, 3, 8'd4);
    idle_cycles(3);
    send_frame(8, 7, 2000, -1, 8'd0);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8 || err_pulses != 0) begin
      n_bad++;
      $display("FAIL men_count got n=%0d err=%0d want 8,0",
               got_i.size(), err_pulses);
    end else begin
      n_vec++;
      if (got_i[0] !== 16'sd2010 || got_q[0] !== -16'sd5 ||
          got_l[7] !== 1'b1) begin
        n_bad++;
        $display("FAIL men_data got %0d,%0d l=%0b want 2010,-5 l=1",
                 got_i[0], got_q[0], got_l[7]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(4, -1, 0, -1, 8'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_rotate_valid !== 1'b0 || o_rotate_last !== 1'b0 ||
        o_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_flags got v=%0b l=%0b e=%0b want 0,0,0",
               o_rotate_valid, o_rotate_last, o_frame_err);
    end
    n_vec++;
    if (o_ram_rot_addr !== 3'd0) begin
      n_bad++; $display("FAIL mrst_addr got %0d want 0", o_ram_rot_addr);
    end
    clear_log();
    drive(1'b1, 1'b0, 16'sd410, -16'sd205);
    drive(1'b1, 1'b0, 16'sd510, -16'sd255);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'sd610, -16'sd305);
    drive(1'b1, 1'b1, 16'sd710, -16'sd355);
    idle_cycles(3);
    send_frame(8, 7, 3000, -1, 8'd0);
    idle_cycles(6);
    n_vec++;
    if (got_i.size() != 8 || err_pulses != 0) begin
      n_bad++;
      $display("FAIL mrst_count got n=%0d err=%0d want 8,0",
               got_i.size(), err_pulses);
    end else begin
      n_vec++;
      if (got_i[0] !== 16'sd3010 || got_l[7] !== 1'b1) begin
        n_bad++;
        $display("FAIL mrst_data got i=%0d l=%0b want 3010,1",
                 got_i[0], got_l[7]);
      end
    end
  endtask

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    err_pulses   = 0;
    mode_req     = 8'd0;
    rst_n        = 1'b0;
    i_mode       = 8'd0;
    i_fft_I_data = '0;
    i_fft_Q_data = '0;
    i_fft_valid  = 1'b0;
    i_fft_last   = 1'b0;
    set_tab(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    test_reset();
    test_identity();
    test_rot90();
    test_saturation();
    test_framing();
    test_frame_err();
    test_mode_clear();
    test_mode_enable();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
